// File: rtl/rcosc_1mhz_monitor.sv
// rcosc_1mhz_monitor
//   Fabric-side monitor for the 1 MHz RC oscillator output. Synchronises the
//   oscillator into the CLK domain, emits a one-cycle TICK per rising edge,
//   measures the period in CLK cycles and tracks lock/fault status.
//
//   Build option: define RCOSC_MON_FREQ_CHECK_EN to enable period range
//   checking (fast/slow faults). When undefined, every period counts as good
//   and only stuck faults can occur.
//
// Ports
//   CLK            fabric clock
//   RESETN         asynchronous active-low reset
//   RCOSC_1MHZ_O2F oscillator output, asynchronous to CLK
//   FAULT_CLR      single-cycle request to leave FAULT
//   TICK           one-cycle pulse per detected oscillator rising edge
//   PERIOD         last measured period in CLK cycles (saturating)
//   PERIOD_VALID   one-cycle pulse when PERIOD updates
//   OSC_OK         high while locked
//   OSC_FAULT      high while faulted
//   FAULT_CODE     00 none, 01 stuck, 10 fast, 11 slow
`timescale 1ns/1ps
module rcosc_1mhz_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned PERIOD_MIN  = 45,
  parameter int unsigned PERIOD_MAX  = 55,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             RCOSC_1MHZ_O2F,
  input  logic             FAULT_CLR,
  output logic             TICK,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             OSC_OK,
  output logic             OSC_FAULT,
  output logic [1:0]       FAULT_CODE
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] StWaitFirst = 2'd0;
  localparam logic [1:0] StMeasure   = 2'd1;
  localparam logic [1:0] StLocked    = 2'd2;
  localparam logic [1:0] StFault     = 2'd3;

  localparam logic [1:0] CodeNone  = 2'b00;
  localparam logic [1:0] CodeStuck = 2'b01;
  localparam logic [1:0] CodeFast  = 2'b10;
  localparam logic [1:0] CodeSlow  = 2'b11;

`ifdef RCOSC_MON_FREQ_CHECK_EN
  localparam bit FreqCheckEn = 1'b1;
`else
  localparam bit FreqCheckEn = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] Timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   PerMin  = (CNT_W + 1)'(PERIOD_MIN);
  localparam logic [CNT_W:0]   PerMax  = (CNT_W + 1)'(PERIOD_MAX);
  localparam logic [GoodW-1:0] GoodOne = GoodW'(1);
  localparam logic [GoodW-1:0] GoodLck = GoodW'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   rise;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         meas;
  logic [CNT_W-1:0]       period_meas;
  logic                   range_ok, in_range, too_fast, stuck, load_period, clr_cnt;
  logic [1:0]             state_q, state_d;
  logic [1:0]             code_q, code_d;
  logic [GoodW-1:0]       good_q, good_d, good_inc;

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

  // CNT+1 carried one bit wider so the range compare never wraps.
  assign meas        = {1'b0, cnt_q} + {1'b0, CntOne};
  assign period_meas = (cnt_q == CntMax) ? CntMax : meas[CNT_W-1:0];
  assign range_ok    = (meas >= PerMin) && (meas <= PerMax);
  assign too_fast    = meas < PerMin;
  assign in_range    = ~FreqCheckEn | range_ok;
  assign stuck       = (cnt_q == Timeout) && !rise;
  assign load_period = rise && (state_q != StWaitFirst);
  assign good_inc    = good_q + GoodOne;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    good_d  = good_q;
    clr_cnt = 1'b0;
    unique case (state_q)
      StWaitFirst: begin
        if (rise) begin
          state_d = StMeasure;
          good_d  = '0;
        end else if (stuck) begin
          state_d = StFault;
          code_d  = CodeStuck;
        end
      end
      StMeasure: begin
        if (rise) begin
          if (in_range) begin
            good_d = good_inc;
            if (good_inc == GoodLck) state_d = StLocked;
          end else begin
            good_d = '0;
          end
        end else if (stuck) begin
          state_d = StFault;
          code_d  = CodeStuck;
        end
      end
      StLocked: begin
        if (rise) begin
          if (!in_range) begin
            state_d = StFault;
            code_d  = too_fast ? CodeFast : CodeSlow;
          end
        end else if (stuck) begin
          state_d = StFault;
          code_d  = CodeStuck;
        end
      end
      StFault: begin
        if (FAULT_CLR) begin
          state_d = StWaitFirst;
          code_d  = CodeNone;
          clr_cnt = 1'b1;
        end
      end
      default: state_d = StWaitFirst;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rise || clr_cnt) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync_q       <= '0;
      dly_q        <= 1'b0;
      cnt_q        <= '0;
      state_q      <= StWaitFirst;
      code_q       <= CodeNone;
      good_q       <= '0;
      TICK         <= 1'b0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
      OSC_OK       <= 1'b0;
      OSC_FAULT    <= 1'b0;
      FAULT_CODE   <= CodeNone;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], RCOSC_1MHZ_O2F};
      dly_q        <= sync_q[SYNC_STAGES-1];
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      code_q       <= code_d;
      good_q       <= good_d;
      TICK         <= rise;
      PERIOD_VALID <= load_period;
      if (load_period) PERIOD <= period_meas;
      // Status outputs lag the state register by one cycle; the code is
      // delayed with them so all three move together.
      OSC_OK       <= (state_q == StLocked);
      OSC_FAULT    <= (state_q == StFault);
      FAULT_CODE   <= code_q;
    end
  end

endmodule
